// File: rtl/upd7801_bus_target.sv
// upd7801_bus_target
//
// Target side of the uPD7801 external bus (A / RDB / WRB / WAITB). A CPU
// access that falls in the decoded window is latched and forwarded to a
// generic synchronous memory port with a level request and a one-CLK ack.
// WAITB is held low until the memory has answered and the minimum wait has
// elapsed. Read data is then presented on DB_O with DB_OE high.
//
// Ports
//   CLK, RESET          system clock, synchronous active-high reset
//   CP1_POSEDGE         CPU phase-1 rising-edge enable (paces the minimum wait)
//   A, A_OE             CPU address and address-valid
//   RDB, WRB            CPU read / write strobes, active low
//   DB_I                CPU write data
//   DB_O, DB_OE         read data to the CPU and its valid/mux select
//   WAITB               wait request to the CPU, active low
//   MEM_ADDR, MEM_WDATA latched access address and write data
//   MEM_RD, MEM_WR      level requests, held until MEM_ACK
//   MEM_RDATA, MEM_ACK  memory read data and one-CLK completion pulse
module upd7801_bus_target #(
  parameter logic [15:0] WIN_BASE = 16'h8000,
  parameter logic [15:0] WIN_MASK = 16'h8000,
  parameter int unsigned MIN_WAIT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CP1_POSEDGE,
  input  logic [15:0] A,
  input  logic        A_OE,
  input  logic        RDB,
  input  logic        WRB,
  input  logic [7:0]  DB_I,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  output logic        WAITB,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  output logic        MEM_RD,
  output logic        MEM_WR,
  input  logic [7:0]  MEM_RDATA,
  input  logic        MEM_ACK
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] wait_cnt_reg;
  logic       ack_seen_reg;

  logic sel;
  logic strobe;
  logic start;
  logic ack_take;
  logic ack_done;
  logic cnt_done;

  assign sel    = A_OE & ((A & WIN_MASK) == WIN_BASE);
  assign strobe = ~RDB | ~WRB;
  assign start  = sel & strobe;

  // Only the first ack of an access is taken; stray acks in IDLE/DONE or a
  // repeated ack in REQ are ignored.
  assign ack_take = (state_reg == ST_REQ) & MEM_ACK & ~ack_seen_reg;
  assign ack_done = ack_seen_reg | ack_take;

  // Counter is either already zero or reaches zero on this CP1 tick, so an
  // ack and the last tick in the same CLK leave REQ without an extra cycle.
  assign cnt_done = (wait_cnt_reg == 4'd0) |
                    ((wait_cnt_reg == 4'd1) & CP1_POSEDGE);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // A CPU that drops its strobes mid-access still gets its memory
        // request completed, but nothing is driven onto the bus afterwards.
        if (ack_done & ~strobe) begin
          state_next = ST_IDLE;
        end else if (ack_done & cnt_done) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Both strobes must go high before another access can start, even
        // if the address moves while a strobe is still low.
        if (~strobe) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: WAITB falls in the same CLK as the strobe so the CPU sees
  // it before its next sample point.
  always_comb begin
    WAITB = ~(start & (state_reg != ST_DONE));
    DB_OE = (state_reg == ST_DONE) & ~RDB & sel;
  end

  // Access datapath: latched address/data, memory request levels, wait
  // counter and read-data register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_ADDR     <= 16'h0000;
      MEM_WDATA    <= 8'h00;
      MEM_RD       <= 1'b0;
      MEM_WR       <= 1'b0;
      DB_O         <= 8'h00;
      wait_cnt_reg <= 4'd0;
      ack_seen_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            MEM_ADDR     <= A;
            MEM_WDATA    <= DB_I;
            // Both strobes low is treated as a read.
            MEM_RD       <= ~RDB;
            MEM_WR       <= RDB;
            wait_cnt_reg <= 4'(MIN_WAIT);
            ack_seen_reg <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ack_take) begin
            MEM_RD       <= 1'b0;
            MEM_WR       <= 1'b0;
            ack_seen_reg <= 1'b1;
            if (MEM_RD) begin
              DB_O <= MEM_RDATA;
            end
          end
          if (CP1_POSEDGE && (wait_cnt_reg != 4'd0)) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/upd7801_bus_target.md
Name: upd7801_bus_target

Overview:
- External-bus responder for the uPD7801 memory interface: it is the target side of the CPU's A/RDB/WRB/WAITB protocol.
- Decodes CPU accesses that fall in a configurable address window and forwards each one to a generic synchronous memory port (SDRAM/BRAM arbiter) using a req/ack handshake.
- Holds WAITB low until the data is ready, then drives read data onto the CPU bus.
- Replaces ad-hoc cart-ROM and wait-generation logic in the system top.

Parameters:
- WIN_BASE, 16'h8000, base address of the decoded window.
- WIN_MASK, 16'h8000, bits of A compared against WIN_BASE. Select = A_OE & ((A & WIN_MASK) == WIN_BASE).
- MIN_WAIT, 0, minimum number of CP1_POSEDGE ticks WAITB stays low per access (0..15).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CP1_POSEDGE  in  1  CPU phase-1 rising-edge clock enable
- A  in  16  CPU address
- A_OE  in  1  CPU address valid
- RDB  in  1  CPU read strobe, active low
- WRB  in  1  CPU write strobe, active low
- DB_I  in  8  CPU write data
- DB_O  out  8  read data to CPU
- DB_OE  out  1  DB_O valid; CPU-side mux selects DB_O when high
- WAITB  out  1  wait request to CPU, active low
- MEM_ADDR  out  16  latched access address
- MEM_WDATA  out  8  latched write data
- MEM_RD  out  1  read request, level
- MEM_WR  out  1  write request, level
- MEM_RDATA  in  8  memory read data, valid with MEM_ACK
- MEM_ACK  in  1  one-CLK completion pulse

Behaviour:
- Reset values: state IDLE; WAITB=1, DB_OE=0, DB_O=0, MEM_RD=0, MEM_WR=0, MEM_ADDR=0, MEM_WDATA=0, wait counter=0.
- start = sel & (~RDB | ~WRB), evaluated every CLK (not gated by CP1).
- WAITB = ~(start & state!=DONE), combinational. It therefore falls in the same CLK the strobe appears, before the CPU's next CP2 sample.
- IDLE, on start:
  - Latch A into MEM_ADDR and DB_I into MEM_WDATA.
  - Assert MEM_RD if RDB low, otherwise MEM_WR.
  - If both strobes are low, the access is a read; a write is not issued.
  - Load the wait counter with MIN_WAIT. Go to REQ.
- REQ:
  - MEM_RD/MEM_WR held until MEM_ACK is seen, cleared in the CLK after the ACK.
  - On ACK of a read, DB_O <= MEM_RDATA. Set ack_seen.
  - Wait counter decrements on each CP1_POSEDGE while nonzero.
  - Go to DONE when ack_seen and counter==0. ACK and counter reaching 0 in the same CLK transition directly.
- DONE:
  - WAITB=1.
  - DB_OE = RDB==0 & sel (combinational, registered data).
  - Stays in DONE while any strobe is low, even if A changes. A new access requires both strobes to go high first.
  - When RDB & WRB are both high: go to IDLE, DB_OE=0.
- Strobe released in REQ (CPU-aborted cycle, should not happen):
  - Keep the memory request until ACK, then go to IDLE without driving DB.
  - WAITB is already high because start=0.
- MEM_ACK while IDLE or DONE: ignored.
- An access outside the window never touches MEM_* and never lowers WAITB.
- Latency with MIN_WAIT=0: memory ack latency + 1 CLK to WAITB high.
- RESET mid-access:
  - Immediately IDLE, MEM_RD/MEM_WR=0 in the next CLK, WAITB=1.
  - A late ACK is ignored.
  - If a strobe is still low after reset with sel, a fresh access starts.
- Write data is captured at the strobe edge only. Changes to DB_I afterwards are ignored.

Test Plan:
- Read A=16'h8123; memory returns 8'h5A with ACK 3 CLKs after MEM_RD -> MEM_ADDR=16'h8123; WAITB low for 4 CLKs then high; DB_O=8'h5A, DB_OE=1 until RDB rises; MEM_RD is a single level held until ACK.
- Write A=16'hC000, DB_I=8'hA5, ACK after 1 CLK -> MEM_WR=1 with MEM_WDATA=8'hA5; DB_OE stays 0; WAITB returns high; IDLE after WRB rises.
- Read A=16'h1000 -> WAITB stays 1, DB_OE=0, MEM_RD never asserted.
- MIN_WAIT=3, ACK after 1 CLK -> WAITB low until the third CP1_POSEDGE after start, then high; DB_O already latched.
- RESET pulsed 2 CLKs into REQ, ACK arrives afterwards -> MEM_RD=0 after reset; ACK ignored; DB_O=0; WAITB=1.
- Back-to-back reads at 16'h8000 then 16'h8001 with one CLK of RDB high between them -> two distinct MEM_RD requests, each returning its own data.
